main_controller: RTL and testbench

Top-level controller of the binary-image skeletonization core. It loads an N×N 8-bit image serially and thins it in place with the Zhang-Suen two-subpass algorithm until no pixel changes. It then raises `done` and exposes the skeleton through a combinational read port. It is the unit instantiated directly by the system/bench.

---
 rtl/skel_pkg.sv | 30 +++
 rtl/main_controller_if.sv | 31 +++
 rtl/main_controller_center_mask.sv | 48 ++++
 rtl/main_controller.sv | 169 ++++++++++++++++
 tb/tb_main_controller.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/skel_pkg.sv
// Shared definitions for the skeletonization core.
//   state_t      : controller states (load, two thinning subpasses, check, done)
//   FG / BG      : stored foreground / background pixel values
//   P2_IDX..P9_IDX : bit positions of the neighbours P2..P9 in the packed
//                  8-bit neighbour vector handed to center_mask
package skel_pkg;

   typedef enum logic [2:0] {
      LOAD  = 3'd0,
      PASS1 = 3'd1,
      PASS2 = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] FG = 8'hFF;
   localparam logic [7:0] BG = 8'h00;

   // Neighbour order is clockwise from north so that the A count can walk
   // the vector cyclically.
   localparam int P2_IDX = 0;  // (r-1, c  )
   localparam int P3_IDX = 1;  // (r-1, c+1)
   localparam int P4_IDX = 2;  // (r  , c+1)
   localparam int P5_IDX = 3;  // (r+1, c+1)
   localparam int P6_IDX = 4;  // (r+1, c  )
   localparam int P7_IDX = 5;  // (r+1, c-1)
   localparam int P8_IDX = 6;  // (r  , c-1)
   localparam int P9_IDX = 7;  // (r-1, c-1)

endpackage

// File: rtl/main_controller_if.sv
// Bus bundle of the skeletonization controller.
//   we, data_in      : serial image load (raster order)
//   rd_addr, data_out: combinational read port (row*N+col)
//   busy, done       : thinning in progress / skeleton final
//   iter_count       : completed iterations that deleted pixels (saturating)
// master = system/bench side, slave = main_controller side.
interface main_controller_if #(
   parameter int N          = 8,
   parameter int bitSize    = $clog2(N*N),
   parameter int pixelWidth = 8
) ();

   logic                  we;
   logic [pixelWidth-1:0] data_in;
   logic [bitSize-1:0]    rd_addr;
   logic [pixelWidth-1:0] data_out;
   logic                  busy;
   logic                  done;
   logic [7:0]            iter_count;

   modport master (
      output we, data_in, rd_addr,
      input  data_out, busy, done, iter_count
   );

   modport slave (
      input  we, data_in, rd_addr,
      output data_out, busy, done, iter_count
   );

endinterface

// File: rtl/main_controller_center_mask.sv
// center_mask: purely combinational Zhang-Suen deletion test for one pixel.
//   nbr      : foreground bits of P2..P9 (indexed by skel_pkg P*_IDX)
//   center   : foreground bit of P1
//   pass_sel : 0 = first subpass, 1 = second subpass
//   del      : pixel must be deleted in this subpass
module center_mask
   import skel_pkg::*;
(
   input  logic [7:0] nbr,
   input  logic       center,
   input  logic       pass_sel,
   output logic       del
);

   logic [3:0] b_cnt;
   logic [3:0] a_cnt;
   logic       p2, p4, p6, p8;
   logic       dir_ok;

   always_comb begin
      b_cnt = '0;
      a_cnt = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         b_cnt = b_cnt + 4'(nbr[3'(i)]);
         // 0->1 transitions around the cyclic sequence P2..P9,P2
         if (!nbr[3'(i)] && nbr[3'((i + 1) % 8)]) begin
            a_cnt = a_cnt + 4'd1;
         end
      end
   end

   assign p2 = nbr[P2_IDX];
   assign p4 = nbr[P4_IDX];
   assign p6 = nbr[P6_IDX];
   assign p8 = nbr[P8_IDX];

   always_comb begin
      if (pass_sel) begin
         dir_ok = !(p2 && p4 && p8) && !(p2 && p6 && p8);
      end else begin
         dir_ok = !(p2 && p4 && p6) && !(p4 && p6 && p8);
      end
   end

   assign del = center && (b_cnt >= 4'd2) && (b_cnt <= 4'd6) &&
                (a_cnt == 4'd1) && dir_ok;

endmodule

// File: rtl/main_controller.sv
// main_controller: top of the binary-image skeletonization core.
// Loads an N x N image serially (one pixel per two clocks), then thins it in
// place with two-subpass Zhang-Suen until an iteration deletes nothing.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : main_controller_if.slave (load, read port, status)
module main_controller
   import skel_pkg::*;
#(
   parameter int N          = 8,
   parameter int bitSize    = $clog2(N*N),
   parameter int pixelWidth = 8
) (
   input logic              clk,
   input logic              rst,
   main_controller_if.slave bus
);

   localparam int unsigned            NPIX      = N * N;
   localparam logic [bitSize:0]       LOAD_END  = (bitSize+1)'(NPIX);
   localparam logic [bitSize-1:0]     LAST_ADDR = bitSize'(NPIX - 1);
   localparam logic [pixelWidth-1:0]  PIX_FG    = pixelWidth'(FG);
   localparam logic [pixelWidth-1:0]  PIX_BG    = pixelWidth'(BG);

   state_t                state_q, state_d;
   logic [pixelWidth-1:0] img_q [NPIX];
   logic [pixelWidth-1:0] img_d [NPIX];
   logic [bitSize:0]      load_addr_q, load_addr_d;
   logic                  phase_q, phase_d;
   logic [bitSize-1:0]    scan_addr_q, scan_addr_d;
   logic [NPIX-1:0]       mark_q, mark_d;
   logic [NPIX-1:0]       mark_all;
   logic                  changed_q, changed_d;
   logic [7:0]            iter_q, iter_d;

   logic [7:0]            nbr;
   logic                  center;
   logic                  del;
   logic                  scan_last;

   // Zero-padded foreground lookup into the live image.
   function automatic logic fg_at(input int r, input int c);
      if (r < 0 || r >= N || c < 0 || c >= N) begin
         return 1'b0;
      end
      return img_q[bitSize'(r * N + c)] != PIX_BG;
   endfunction

   always_comb begin
      int row;
      int col;
      row = int'(scan_addr_q) / N;
      col = int'(scan_addr_q) % N;
      center       = fg_at(row, col);
      nbr          = '0;
      nbr[P2_IDX]  = fg_at(row - 1, col);
      nbr[P3_IDX]  = fg_at(row - 1, col + 1);
      nbr[P4_IDX]  = fg_at(row,     col + 1);
      nbr[P5_IDX]  = fg_at(row + 1, col + 1);
      nbr[P6_IDX]  = fg_at(row + 1, col);
      nbr[P7_IDX]  = fg_at(row + 1, col - 1);
      nbr[P8_IDX]  = fg_at(row,     col - 1);
      nbr[P9_IDX]  = fg_at(row - 1, col - 1);
   end

   center_mask u_center_mask (
      .nbr      (nbr),
      .center   (center),
      .pass_sel (state_q == PASS2),
      .del      (del)
   );

   assign scan_last = (scan_addr_q == LAST_ADDR);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (load_addr_q == LOAD_END) state_d = PASS1;
         PASS1:   if (scan_last) state_d = PASS2;
         PASS2:   if (scan_last) state_d = CHECK;
         CHECK:   state_d = changed_q ? PASS1 : DONE;
         DONE:    state_d = DONE;
         default: state_d = LOAD;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.busy = (state_q == PASS1) || (state_q == PASS2) || (state_q == CHECK);
      bus.done = (state_q == DONE);
   end

   assign bus.iter_count = iter_q;
   assign bus.data_out   = img_q[bus.rd_addr];

   // Datapath next values
   always_comb begin
      img_d       = img_q;
      load_addr_d = load_addr_q;
      phase_d     = phase_q;
      scan_addr_d = scan_addr_q;
      mark_d      = mark_q;
      changed_d   = changed_q;
      iter_d      = iter_q;
      mark_all    = mark_q;

      case (state_q)
         LOAD: begin
            phase_d = ~phase_q;
            if (!phase_q && bus.we && load_addr_q != LOAD_END) begin
               img_d[load_addr_q[bitSize-1:0]] = (bus.data_in != '0) ? PIX_FG : PIX_BG;
               load_addr_d = load_addr_q + (bitSize+1)'(1);
            end
         end
         PASS1, PASS2: begin
            // The image is untouched until the subpass ends, so every
            // decision in the scan sees the subpass-start image.
            mark_all[scan_addr_q] = mark_q[scan_addr_q] | del;
            changed_d = changed_q | del;
            if (scan_last) begin
               for (int unsigned i = 0; i < NPIX; i++) begin
                  if (mark_all[bitSize'(i)]) img_d[bitSize'(i)] = PIX_BG;
               end
               mark_d      = '0;
               scan_addr_d = '0;
            end else begin
               mark_d      = mark_all;
               scan_addr_d = scan_addr_q + bitSize'(1);
            end
         end
         CHECK: begin
            if (changed_q && iter_q != 8'hFF) iter_d = iter_q + 8'd1;
         end
         default: ;
      endcase

      if (state_q != PASS1 && state_d == PASS1) changed_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         img_q       <= '{default: '0};
         load_addr_q <= '0;
         phase_q     <= 1'b0;
         scan_addr_q <= '0;
         mark_q      <= '0;
         changed_q   <= 1'b0;
         iter_q      <= '0;
      end else begin
         img_q       <= img_d;
         load_addr_q <= load_addr_d;
         phase_q     <= phase_d;
         scan_addr_q <= scan_addr_d;
         mark_q      <= mark_d;
         changed_q   <= changed_d;
         iter_q      <= iter_d;
      end
   end

endmodule

// File: tb/tb_main_controller.sv
// Bench for main_controller (N=8): each loaded image has its expected final
// skeleton, iteration count and busy duration pushed to a scoreboard; a
// monitor pops and compares once the DUT raises done.
module tb_main_controller;

   localparam int N   = 8;
   localparam int NP  = N * N;
   localparam int ITC = 2 * NP + 1;

   typedef struct packed {
      logic [63:0] fg;
      logic [7:0]  iters;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   checked_cnt;
   int   runs;
   exp_t sb_q[$];

   main_controller_if #(.N(N), .bitSize(6), .pixelWidth(8)) bus ();

   main_controller #(.N(N), .bitSize(6), .pixelWidth(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Software Zhang-Suen on a 2-D array.
   function automatic int px(input int img[8][8], input int r, input int c);
      if (r < 0 || r > 7 || c < 0 || c > 7) return 0;
      return img[r][c];
   endfunction

   function automatic void zs_model(input logic [63:0] in, output logic [63:0] out,
                                    output int iters);
      int img[8][8];
      int mark[8][8];
      int dr[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
      int dc[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
      int p[8];
      int b, a, ok, any, guard;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) img[r][c] = in[r*8+c] ? 1 : 0;
      iters = 0;
      guard = 0;
      do begin
         any = 0;
         for (int sub = 0; sub < 2; sub++) begin
            for (int r = 0; r < 8; r++) begin
               for (int c = 0; c < 8; c++) begin
                  mark[r][c] = 0;
                  if (img[r][c] == 1) begin
                     b = 0;
                     a = 0;
                     for (int k = 0; k < 8; k++) p[k] = px(img, r + dr[k], c + dc[k]);
                     for (int k = 0; k < 8; k++) begin
                        b += p[k];
                        if (p[k] == 0 && p[(k+1)%8] == 1) a++;
                     end
                     if (sub == 0) ok = (p[0]*p[2]*p[4] == 0) && (p[2]*p[4]*p[6] == 0);
                     else          ok = (p[0]*p[2]*p[6] == 0) && (p[0]*p[4]*p[6] == 0);
                     if (b >= 2 && b <= 6 && a == 1 && ok != 0) mark[r][c] = 1;
                  end
               end
            end
            for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++)
                  if (mark[r][c] == 1) begin
                     img[r][c] = 0;
                     any = 1;
                  end
         end
         if (any != 0) iters++;
         guard++;
      end while (any != 0 && guard < 100);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) out[r*8+c] = (img[r][c] != 0);
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      bus.we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called right after reset release on a negedge: the next posedge is phase 0.
   task automatic load_image(input logic [63:0] img, input int pause_after);
      for (int k = 0; k < NP; k++) begin
         bus.we      = 1'b1;
         bus.data_in = img[k] ? 8'($urandom_range(1, 255)) : 8'h00;
         repeat (2) @(negedge clk);
         if (k == pause_after) begin
            bus.we      = 1'b0;
            bus.data_in = 8'($urandom_range(1, 255));
            repeat (10) @(negedge clk);
         end
      end
      bus.we = 1'b0;
   endtask

   task automatic wait_checked(input int target);
      int n;
      n = 0;
      while (checked_cnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", (checked_cnt >= target) ? 1 : 0, 1);
   endtask

   task automatic run_image(input logic [63:0] img, input int pause_after);
      logic [63:0] fin;
      int          it;
      exp_t        e;
      apply_reset();
      zs_model(img, fin, it);
      e.fg    = fin;
      e.iters = 8'(it);
      sb_q.push_back(e);
      runs++;
      load_image(img, pause_after);
      wait_checked(runs);
   endtask

   // Monitor: counts busy cycles since reset, checks on the rise of done.
   initial begin
      int   busy_cnt;
      bit   handled;
      exp_t e;
      busy_cnt = 0;
      handled  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
            handled  = 1'b0;
         end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done && !handled) begin
               handled = 1'b1;
               check("busy_at_done", int'(bus.busy), 0);
               if (sb_q.size() == 0) begin
                  check("sb_underflow", 0, 1);
               end else begin
                  e = sb_q.pop_front();
                  check("iter_count", int'(bus.iter_count), int'(e.iters));
                  check("busy_cycles", busy_cnt, (int'(e.iters) + 1) * ITC);
                  for (int a = 0; a < NP; a++) begin
                     bus.rd_addr = 6'(a);
                     #1;
                     check($sformatf("pixel[%0d]", a), int'(bus.data_out),
                           e.fg[a] ? 255 : 0);
                  end
               end
               checked_cnt++;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] img;
      logic [63:0] line_img;
      errors      = 0;
      checks      = 0;
      checked_cnt = 0;
      runs        = 0;
      rst         = 1'b1;
      bus.we      = 1'b0;
      bus.data_in = '0;
      bus.rd_addr = 6'd27;
      #3;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_iter", int'(bus.iter_count), 0);
      check("rst_pixel27", int'(bus.data_out), 0);
      @(negedge clk);

      // all background
      run_image(64'h0, -1);
      // single isolated pixel at (3,3)
      img = '0;
      img[27] = 1'b1;
      run_image(img, -1);
      // full foreground
      run_image({64{1'b1}}, -1);
      // thick horizontal bar: rows 3..5, cols 1..6
      line_img = '0;
      for (int r = 3; r <= 5; r++)
         for (int c = 1; c <= 6; c++) line_img[r*8+c] = 1'b1;
      run_image(line_img, -1);
      // random blob with a 10-clock load pause after pixel 20
      for (int i = 0; i < NP; i++) img[i] = ($urandom_range(0, 9) < 6);
      run_image(img, 20);
      run_image(img, -1);

      // reset in the middle of PASS2, then reload the same image
      apply_reset();
      load_image(line_img, -1);
      repeat (NP + 20) @(negedge clk);
      check("busy_in_pass2", int'(bus.busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_done", int'(bus.done), 0);
      check("async_rst_iter", int'(bus.iter_count), 0);
      bus.rd_addr = 6'd35;
      #1;
      check("async_rst_cleared", int'(bus.data_out), 0);
      @(negedge clk);
      run_image(line_img, -1);

      // further random images
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < NP; i++) img[i] = ($urandom_range(0, 9) < 5);
         run_image(img, -1);
      end

      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
